mem_read_port_arbiter: RTL
==========================

// Module: mem_read_port_arbiter
// PURPOSE
//  Shares the single synchronous read port of a Memory instance between NUM_REQ requesters.
//  - Round-robin arbitration, one read grant per cycle.
//  - Fixed-latency responses, each tagged and routed back to the requester that issued it.
//  - Sits between client read logic and Memory RADDR/RDATA; the write port is not touched.
// PARAMETERS
//  NUM_REQ       2  number of read requesters (>=2)
//  ADDR_WIDTH    2  memory address width
//  DATA_WIDTH    5  memory data width
//  READ_LATENCY  2  cycles from MEM_RADDR to valid MEM_RDATA (sync read + output register)
// PORTS
//  CLK        in   1                     clock; all state updates on rising edge
//  RESET      in   1                     synchronous, active-high reset
//  REQ_VALID  in   NUM_REQ               per-requester read request valid
//  REQ_ADDR   in   NUM_REQ*ADDR_WIDTH    per-requester address; requester i at [i*AW +: AW]
//  REQ_READY  out  NUM_REQ               one-hot grant; request i is accepted when VALID[i] && READY[i]
//  RESP_VALID out  NUM_REQ               one-hot response strobe, single-cycle pulse
//  RESP_DATA  out  DATA_WIDTH            read data, shared by all requesters; qualified by RESP_VALID
//  MEM_RADDR  out  ADDR_WIDTH            to Memory RADDR
//  MEM_REN    out  1                     high in a cycle where a grant issues
//  MEM_RDATA  in   DATA_WIDTH            from Memory RDATA
// BEHAVIOUR
//  - Reset state:
//    - REQ_READY=0, RESP_VALID=0, MEM_REN=0, MEM_RADDR=0, RESP_DATA=0.
//    - Priority pointer = 0.
//    - Tag pipeline cleared.
//  - Arbitration is combinational on REQ_VALID and the pointer.
//    - The grant goes to the first valid requester at or after the pointer, modulo NUM_REQ.
//    - REQ_READY is asserted only for the granted requester, and only while RESET=0.
//    - With no valid request: REQ_READY=0, MEM_REN=0, MEM_RADDR holds its last value.
//  - MEM_RADDR = address of the granted requester in the same cycle.
//    - MEM_REN = |(REQ_VALID & REQ_READY).
//  - Pointer update on a grant to requester g: pointer <= (g+1) mod NUM_REQ. No grant: pointer unchanged.
//  - Tag pipeline: READ_LATENCY stages, each holding {valid, id[$clog2(NUM_REQ)-1:0]}.
//    - Stage 0 loads {MEM_REN, g} every cycle.
//    - At the output stage, RESP_VALID[id] = valid.
//    - RESP_DATA is registered: it captures MEM_RDATA when the tag arrives.
//    - Net request-to-response latency: READ_LATENCY+1 cycles, i.e. grant at cycle t -> RESP_VALID at t+3 by default.
//  - Throughput: one accepted read per cycle sustained. Responses return in grant order.
//  - No response backpressure: requesters must consume RESP_DATA in the RESP_VALID cycle.
//  - REQ_ADDR and REQ_VALID may change freely when not accepted; no hold requirement.
//  - Boundary conditions:
//    - All requesters valid every cycle: strict rotation 0,1,...,NUM_REQ-1,0.
//    - Single requester valid: granted every cycle, pointer still advances.
//    - Write in the same cycle and same address as a granted read: the read returns the pre-write data, per Memory semantics. The arbiter takes no action.
//    - RESET mid-operation: all in-flight tags are dropped; no RESP_VALID pulses until new grants, including for reads issued before reset.
//    - NUM_REQ not a power of two: the pointer wraps explicitly at NUM_REQ-1; it never points at a nonexistent requester.
// STRUCTURE
//  - Shared package holds:
//    - localparam ID_WIDTH = $clog2(NUM_REQ), with a minimum of 1;
//    - typedef struct packed {logic valid; logic [ID_WIDTH-1:0] id;} rd_tag_t.
//  - One sub-module: rr_arbiter (REQ in, one-hot GNT out, pointer register, CLK/RESET).
//  - The tag shift register and response demux live in the top module.
// TESTING (NUM_REQ=2, AW=2, DW=5, READ_LATENCY=2; bench models Memory with preload mem[i]=5'h10+i)
//  - Reset then idle 10 cycles -> REQ_READY=0, RESP_VALID=0, MEM_REN=0 throughout.
//  - Req0 only, addr=2, one cycle -> READY[0]=1 at t, MEM_RADDR=2; RESP_VALID=2'b01, RESP_DATA=5'h12 at t+3.
//  - Both valid for 4 cycles, addr0=1, addr1=3 -> grants 0,1,0,1; responses 5'h11,5'h13,5'h11,5'h13 on RESP_VALID bits 0,1,0,1 at t+3..t+6.
//  - Req1 grant at t, RESET at t+1 -> no RESP_VALID at t+3; the next grant after reset goes to requester 0 if valid.
//  - Write 5'h1F to addr 0 with read of addr 0 in the same cycle -> response 5'h10; a read of addr 0 next cycle returns 5'h1F.
//  - Random VALID/ADDR for 2000 cycles vs scoreboard -> every accepted read gets exactly one response, in order, with correct id and data.

Source files
------------

// File: rtl/mem_read_port_arbiter_pkg.sv
// Shared types for the memory read-port arbiter: tag width and the in-flight read tag.
package mem_read_port_arbiter_pkg;

   localparam int DEF_NUM_REQ = 2;
   // Tag id width follows the default requester count; raise DEF_NUM_REQ when instantiating wider.
   localparam int ID_WIDTH = (DEF_NUM_REQ > 2) ? $clog2(DEF_NUM_REQ) : 1;

   typedef struct packed {
      logic                valid;
      logic [ID_WIDTH-1:0] id;
   } rd_tag_t;

endpackage

// File: rtl/mem_read_port_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after the pointer.
module rr_arbiter
   import mem_read_port_arbiter_pkg::*;
#(
   parameter int NUM_REQ = DEF_NUM_REQ
) (
   input  logic                clk_i,
   input  logic                reset_i,
   input  logic [NUM_REQ-1:0]  req_i,
   output logic [NUM_REQ-1:0]  gnt_o,
   output logic [ID_WIDTH-1:0] gnt_id_o
);

   logic [ID_WIDTH-1:0] ptr_q, ptr_d;
   logic [ID_WIDTH-1:0] cand;
   logic                found;
   int                  idx;

   always_comb begin
      gnt_o    = '0;
      gnt_id_o = '0;
      found    = 1'b0;
      idx      = 0;
      cand     = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         // Explicit wrap so non-power-of-two counts never select a missing requester.
         idx = int'(ptr_q) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         cand = ID_WIDTH'(idx);
         if (!found && !reset_i && req_i[cand]) begin
            found       = 1'b1;
            gnt_o[cand] = 1'b1;
            gnt_id_o    = cand;
         end
      end
      ptr_d = ptr_q;
      if (found) ptr_d = (gnt_id_o == ID_WIDTH'(NUM_REQ-1)) ? '0 : gnt_id_o + 1'b1;
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) ptr_q <= '0;
      else         ptr_q <= ptr_d;
   end

endmodule

// File: rtl/mem_read_port_arbiter.sv
// Shares one synchronous memory read port between NUM_REQ requesters; tagged fixed-latency responses.
module mem_read_port_arbiter
   import mem_read_port_arbiter_pkg::*;
#(
   parameter int NUM_REQ      = DEF_NUM_REQ,
   parameter int ADDR_WIDTH   = 2,
   parameter int DATA_WIDTH   = 5,
   parameter int READ_LATENCY = 2
) (
   input  logic                          clk_i,
   input  logic                          reset_i,
   input  logic [NUM_REQ-1:0]            req_valid_i,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i,
   output logic [NUM_REQ-1:0]            req_ready_o,
   output logic [NUM_REQ-1:0]            resp_valid_o,
   output logic [DATA_WIDTH-1:0]         resp_data_o,
   output logic [ADDR_WIDTH-1:0]         mem_raddr_o,
   output logic                          mem_ren_o,
   input  logic [DATA_WIDTH-1:0]         mem_rdata_i
);

   logic [NUM_REQ-1:0]    gnt;
   logic [ID_WIDTH-1:0]   gnt_id;
   logic [ADDR_WIDTH-1:0] raddr_q;
   logic [NUM_REQ-1:0]    resp_valid_q, resp_valid_d;
   logic [DATA_WIDTH-1:0] resp_data_q;
   rd_tag_t               tag_q [READ_LATENCY];
   rd_tag_t               out_tag;

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .req_i   (req_valid_i),
      .gnt_o   (gnt),
      .gnt_id_o(gnt_id)
   );

   assign req_ready_o = gnt;
   assign mem_ren_o   = |(req_valid_i & gnt);
   // Address holds its last value when idle so the memory sees no spurious toggles.
   assign mem_raddr_o = reset_i   ? '0 :
                        mem_ren_o ? req_addr_i[gnt_id*ADDR_WIDTH +: ADDR_WIDTH] : raddr_q;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         for (int i = 0; i < READ_LATENCY; i++) tag_q[i] <= '0;
      end else begin
         tag_q[0] <= '{valid: mem_ren_o, id: gnt_id};
         for (int i = 1; i < READ_LATENCY; i++) tag_q[i] <= tag_q[i-1];
      end
   end

   assign out_tag = tag_q[READ_LATENCY-1];

   always_comb begin
      resp_valid_d = '0;
      if (out_tag.valid) resp_valid_d[out_tag.id] = 1'b1;
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         resp_valid_q <= '0;
         resp_data_q  <= '0;
         raddr_q      <= '0;
      end else begin
         resp_valid_q <= resp_valid_d;
         if (out_tag.valid) resp_data_q <= mem_rdata_i;
         raddr_q <= mem_raddr_o;
      end
   end

   assign resp_valid_o = resp_valid_q;
   assign resp_data_o  = resp_data_q;

endmodule
